// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges memory-wait freeze, taken-branch flush and load-use bubble.
// Enables are combinational from inputs+state (0 latency); state and counters update on clk.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRt,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             MEMWBBubble,
  output logic             memError,
  output logic [CNT_W-1:0] stallCount
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt, wait_d;
  logic            mem_stall, load_use, freeze, stall_cycle;
  logic            mem_error_q;
  logic [CNT_W-1:0] stall_cnt;

  assign mem_stall = memReq && !memReady;
  assign load_use  = IDEXMemRead && (IDEXRt != 5'd0) &&
                     ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));
  assign freeze    = (state_q == MEM_ERR) || mem_stall;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        // A withdrawn request ends the wait just like a completion.
        if (!memReq || memReady) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          state_d = MEM_ERR;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      MEM_ERR: state_d = MEM_ERR;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXBubble  = 1'b0;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    stall_cycle = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (freeze) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
      stall_cycle = 1'b1;
    end else if (branchTaken) begin
      // The ID instruction is squashed, so a pending load-use is moot.
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (load_use) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXBubble  = 1'b1;
      stall_cycle = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      mem_error_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (state_d == MEM_ERR)
        mem_error_q <= 1'b1;
      if (stall_cycle && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign memError   = mem_error_q;
  assign stallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboarded random + directed bench for pipeline_stall_controller against a behavioural model.
module tb_pipeline_stall_controller;

  localparam int TO = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic pcw, ifidw, ifidf, idexb, idexw, exmemw, memwbb, memerr;
  } ctl_t;

  typedef struct packed {
    ctl_t          ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          IDEXMemRead;
  logic [4:0]    IDEXRt, IFIDRs, IFIDRt;
  logic          branchTaken, memReq, memReady;
  logic          PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXWrite, EXMEMWrite, MEMWBBubble;
  logic          memError;
  logic [CW-1:0] stallCount;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .branchTaken(branchTaken), .memReq(memReq),
    .memReady(memReady), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .MEMWBBubble(MEMWBBubble), .memError(memError), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Model: memory request outstanding / timed out, cycles spent waiting, stalled cycles.
  bit m_wait, m_err;
  int m_wcnt, m_cnt;

  function automatic exp_t predict(input logic rst, lr, input logic [4:0] rt, rs, rtt,
                                   input logic br, req, rdy);
    exp_t e;
    bit   lu  = lr && rt != 0 && (rt == rs || rt == rtt);
    bit   frz = m_err || (req && !rdy);
    if (rst)      e.ctl = '{0, 0, 1, 1, 0, 0, 1, 0};
    else if (frz) e.ctl = '{0, 0, 0, 0, 0, 0, 1, 0};
    else if (br)  e.ctl = '{1, 1, 1, 1, 1, 1, 0, 0};
    else if (lu)  e.ctl = '{0, 0, 0, 1, 1, 1, 0, 0};
    else          e.ctl = '{1, 1, 0, 0, 1, 1, 0, 0};
    e.ctl.memerr = m_err;
    e.cnt = CW'(m_cnt);
    return e;
  endfunction

  task automatic advance(input logic rst, lr, input logic [4:0] rt, rs, rtt,
                         input logic br, req, rdy);
    bit lu  = lr && rt != 0 && (rt == rs || rt == rtt);
    bit frz = m_err || (req && !rdy);
    if (rst) begin
      m_wait = 0; m_err = 0; m_wcnt = 0; m_cnt = 0;
      return;
    end
    if (frz || (!br && lu)) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (m_err) return;
    if (m_wait) begin
      if (!req || rdy) m_wait = 0;
      else if (m_wcnt == TO - 1) begin m_err = 1; m_wait = 0; end
      else m_wcnt++;
    end else if (req && !rdy) begin
      m_wait = 1; m_wcnt = 0;
    end
  endtask

  // Called #1 after a rising edge; drives one cycle, queues its expectation, then advances.
  task automatic step(input logic rst, lr, input logic [4:0] rt, rs, rtt,
                      input logic br, req, rdy);
    reset = rst; IDEXMemRead = lr; IDEXRt = rt; IFIDRs = rs; IFIDRt = rtt;
    branchTaken = br; memReq = req; memReady = rdy;
    exp_q.push_back(predict(rst, lr, rt, rs, rtt, br, req, rdy));
    @(posedge clk);
    advance(rst, lr, rt, rs, rtt, br, req, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t got;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXWrite, EXMEMWrite,
              MEMWBBubble, memError};
      n_cmp++;
      if (got !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl cycle %0d: got pcw,ifidw,flush,idexb,idexw,exmemw,memwbb,err=%b want %b",
                 cyc, got, e.ctl);
      end
      n_cmp++;
      if (stallCount !== e.cnt) begin
        n_bad++;
        $display("FAIL stallCount cycle %0d: got %0d want %0d", cyc, stallCount, e.cnt);
      end
    end
  end

  initial begin
    logic       req, rdy, rst;
    logic [4:0] rt;
    reset = 1; IDEXMemRead = 0; IDEXRt = 0; IFIDRs = 0; IFIDRt = 0;
    branchTaken = 0; memReq = 0; memReady = 0;
    m_wait = 0; m_err = 0; m_wcnt = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs, then on rt, then r0 (no hazard).
    step(0, 1, 5, 5, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 7, 1, 7, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 4, 6, 0, 0, 0);
    // Branch beats load-use.
    step(0, 1, 5, 5, 5, 1, 0, 0);
    idle(1);
    // Memory wait 3 cycles, release on the 4th; memReady without memReq is ignored.
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 5, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Timeout into MEM_ERR, sticky until reset.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 2, 2, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Saturation of stallCount via repeated load-use stalls.
    for (int i = 0; i < CMAX + 3; i++) step(0, 1, 9, 9, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic; a request is held until the model sees it finish.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      req = m_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
      rdy = $urandom_range(0, 2) != 0 ? 1'b1 : 1'b0;
      if ($urandom_range(0, 3) == 0) rdy = 0;
      rt  = 5'($urandom_range(0, 3));
      step(rst, 1'($urandom_range(0, 1)), rt, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), req, rdy);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
